cordic_rr_arbiter: RTL and testbench

Shares one CORDIC pipeline between N_REQ independent AXI-stream requesters using round-robin issue arbitration. Each issued operand set is tagged with its requester ID in an in-order tag FIFO. Results returning from the pipeline are routed back to the originating requester. Sits between requester engines and the CORDIC top-level stream ports (tvalid_data_i/tready_data_i in, tvalid_data_o/tready_data_o out).

---
 rtl/cordic_arb_pkg.sv | 21 ++
 rtl/cordic_tag_fifo.sv | 67 ++++++
 rtl/cordic_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_cordic_rr_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared types for the CORDIC round-robin arbiter: requester ID type and width helper.
package cordic_arb_pkg;

  localparam int unsigned MaxReq = 16;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Sized for the largest supported requester count so every instance shares one tag type.
  localparam int unsigned IdW = id_width(MaxReq);

  typedef logic [IdW-1:0] req_id_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] z;
  } cordic_beat_t;

endpackage

// File: rtl/cordic_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per operand set still inside the CORDIC pipeline.
module cordic_tag_fifo
  import cordic_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  req_id_t         id_i,
  input  logic            pop_i,
  output req_id_t         id_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  req_id_t         mem_q [DEPTH];
  req_id_t         mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign id_o    = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = id_i;
      wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cordic_rr_arbiter.sv
// Round-robin sharing of one CORDIC pipeline between N_REQ stream requesters, with results
// routed back to their originators through an in-order tag FIFO.
module cordic_rr_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MAX_INFLIGHT = 16,
  localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [N_REQ-1:0]            req_tvalid_i,
  output logic [N_REQ-1:0]            req_tready_o,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_x_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_y_i,
  input  logic [N_REQ*32-1:0]         req_z_i,
  output logic                        cor_tvalid_o,
  input  logic                        cor_tready_i,
  output logic [DATA_WIDTH-1:0]       cor_x_o,
  output logic [DATA_WIDTH-1:0]       cor_y_o,
  output logic [31:0]                 cor_z_o,
  input  logic                        res_tvalid_i,
  output logic                        res_tready_o,
  input  logic [DATA_WIDTH-1:0]       res_x_i,
  input  logic [DATA_WIDTH-1:0]       res_y_i,
  input  logic [31:0]                 res_z_i,
  output logic [N_REQ-1:0]            rsp_tvalid_o,
  input  logic [N_REQ-1:0]            rsp_tready_i,
  output logic [DATA_WIDTH-1:0]       rsp_x_o,
  output logic [DATA_WIDTH-1:0]       rsp_y_o,
  output logic [31:0]                 rsp_z_o,
  output logic [CntW-1:0]             inflight_o,
  output logic                        err_o
);

  localparam req_id_t LastId = req_id_t'(N_REQ - 1);

  logic [MaxReq-1:0] req_valid_ext, rsp_ready_ext;
  req_id_t           rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d, gnt_id, head_id, arb_idx;
  logic [IdW:0]      arb_sum;
  logic              lock_q, lock_d, err_q, err_d;
  logic              gnt_valid, issue_ok, push, pop, fifo_full, fifo_empty;

  // Zero-extend so a full-width ID can index without width mismatches.
  assign req_valid_ext = MaxReq'(req_tvalid_i);
  assign rsp_ready_ext = MaxReq'(rsp_tready_i);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = rr_ptr_q;
    arb_sum   = '0;
    arb_idx   = '0;
    if (lock_q) begin
      gnt_valid = 1'b1;
      gnt_id    = lock_id_q;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        arb_sum = {1'b0, rr_ptr_q} + (IdW + 1)'(i);
        if (arb_sum > {1'b0, LastId}) arb_sum = arb_sum - (IdW + 1)'(N_REQ);
        arb_idx = arb_sum[IdW-1:0];
        if (!gnt_valid && req_valid_ext[arb_idx]) begin
          gnt_valid = 1'b1;
          gnt_id    = arb_idx;
        end
      end
    end
  end

  // Full FIFO blocks issue outright, independent of the return side.
  assign issue_ok     = ~fifo_full;
  assign cor_tvalid_o = gnt_valid & issue_ok;
  assign push         = cor_tvalid_o & cor_tready_i;

  always_comb begin
    req_tready_o = '0;
    cor_x_o      = '0;
    cor_y_o      = '0;
    cor_z_o      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_id == req_id_t'(k)) begin
        req_tready_o[k] = gnt_valid & issue_ok & cor_tready_i;
        cor_x_o         = req_x_i[k*DATA_WIDTH +: DATA_WIDTH];
        cor_y_o         = req_y_i[k*DATA_WIDTH +: DATA_WIDTH];
        cor_z_o         = req_z_i[k*32 +: 32];
      end
    end
  end

  assign res_tready_o = fifo_empty ? 1'b1 : rsp_ready_ext[head_id];
  assign pop          = res_tvalid_i & res_tready_o & ~fifo_empty;
  assign rsp_x_o      = res_x_i;
  assign rsp_y_o      = res_y_i;
  assign rsp_z_o      = res_z_i;
  assign err_o        = err_q;

  always_comb begin
    rsp_tvalid_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      rsp_tvalid_o[k] = res_tvalid_i & ~fifo_empty & (head_id == req_id_t'(k));
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q | (res_tvalid_i & fifo_empty);
    if (push) begin
      rr_ptr_d = (gnt_id == LastId) ? '0 : req_id_t'(gnt_id + 1'b1);
      lock_d   = 1'b0;
    end else if (cor_tvalid_o) begin
      lock_d    = 1'b1;
      lock_id_d = gnt_id;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  cordic_tag_fifo #(
    .DEPTH(MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk_i  (aclk),
    .rst_i  (areset),
    .push_i (push),
    .id_i   (gnt_id),
    .pop_i  (pop),
    .id_o   (head_id),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(inflight_o)
  );

endmodule

// File: tb/tb_cordic_rr_arbiter.sv
// Directed bench for cordic_rr_arbiter: table-driven issue arbitration plus return-path sequences.
module tb_cordic_rr_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 4;
  localparam int unsigned MI = 16;
  localparam int unsigned CW = 5;

  logic             aclk = 1'b0;
  logic             areset;
  logic [NR-1:0]    req_tvalid, req_tready;
  logic [NR*DW-1:0] req_x, req_y;
  logic [NR*32-1:0] req_z;
  logic             cor_tvalid, cor_tready;
  logic [DW-1:0]    cor_x, cor_y;
  logic [31:0]      cor_z;
  logic             res_tvalid, res_tready;
  logic [DW-1:0]    res_x, res_y;
  logic [31:0]      res_z;
  logic [NR-1:0]    rsp_tvalid, rsp_tready;
  logic [DW-1:0]    rsp_x, rsp_y;
  logic [31:0]      rsp_z;
  logic [CW-1:0]    inflight;
  logic             err;

  always #5 aclk = ~aclk;

  cordic_rr_arbiter #(
    .DATA_WIDTH  (DW),
    .N_REQ       (NR),
    .MAX_INFLIGHT(MI)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .req_tvalid_i(req_tvalid),
    .req_tready_o(req_tready),
    .req_x_i     (req_x),
    .req_y_i     (req_y),
    .req_z_i     (req_z),
    .cor_tvalid_o(cor_tvalid),
    .cor_tready_i(cor_tready),
    .cor_x_o     (cor_x),
    .cor_y_o     (cor_y),
    .cor_z_o     (cor_z),
    .res_tvalid_i(res_tvalid),
    .res_tready_o(res_tready),
    .res_x_i     (res_x),
    .res_y_i     (res_y),
    .res_z_i     (res_z),
    .rsp_tvalid_o(rsp_tvalid),
    .rsp_tready_i(rsp_tready),
    .rsp_x_o     (rsp_x),
    .rsp_y_o     (rsp_y),
    .rsp_z_o     (rsp_z),
    .inflight_o  (inflight),
    .err_o       (err)
  );

  typedef struct {
    logic [3:0] vld;
    logic       rdy;
    logic       exp_cv;
    logic [1:0] exp_id;
    logic [3:0] exp_trdy;
    logic [4:0] exp_inf;
  } vec_t;

  vec_t tbl[10];
  int   total = 0;
  int   bad = 0;
  int   exp_ids[7] = '{2, 3, 0, 2, 0, 1, 3};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    // {valid, cor_tready} -> {cor_tvalid, granted id, req_tready, inflight before edge}
    tbl[0] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 5'd0};
    tbl[1] = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100, 5'd0};
    tbl[2] = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000, 5'd1};
    tbl[3] = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 5'd2};
    tbl[4] = '{4'b0101, 1'b0, 1'b1, 2'd2, 4'b0000, 5'd3};
    tbl[5] = '{4'b0111, 1'b0, 1'b1, 2'd2, 4'b0000, 5'd3};
    tbl[6] = '{4'b0111, 1'b1, 1'b1, 2'd2, 4'b0100, 5'd3};
    tbl[7] = '{4'b0011, 1'b1, 1'b1, 2'd0, 4'b0001, 5'd4};
    tbl[8] = '{4'b0011, 1'b1, 1'b1, 2'd1, 4'b0010, 5'd5};
    tbl[9] = '{4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000, 5'd6};

    for (int k = 0; k < NR; k++) begin
      req_x[k*DW +: DW] = DW'(16'h0100 + k);
      req_y[k*DW +: DW] = DW'(16'h0200 + k);
      req_z[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    end
    areset = 1'b1; req_tvalid = '0; cor_tready = 1'b0;
    res_tvalid = 1'b0; res_x = '0; res_y = '0; res_z = '0; rsp_tready = '0;
    tick(); tick();
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cor_tvalid", 64'(cor_tvalid), 64'd0);
    chk("rst_req_tready", 64'(req_tready), 64'd0);
    chk("rst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
    areset = 1'b0;
    tick();

    // Arbitration, rotation and lock-on-backpressure.
    for (int i = 0; i < 10; i++) begin
      req_tvalid = tbl[i].vld;
      cor_tready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_cor_tvalid", i), 64'(cor_tvalid), 64'(tbl[i].exp_cv));
      chk($sformatf("v%0d_req_tready", i), 64'(req_tready), 64'(tbl[i].exp_trdy));
      chk($sformatf("v%0d_inflight", i), 64'(inflight), 64'(tbl[i].exp_inf));
      if (tbl[i].exp_cv) begin
        chk($sformatf("v%0d_cor_x", i), 64'(cor_x), 64'(16'h0100 + 16'(tbl[i].exp_id)));
        chk($sformatf("v%0d_cor_z", i), 64'(cor_z), 64'(32'hA000_0000 + 32'(tbl[i].exp_id)));
      end
      tick();
    end
    req_tvalid = '0;
    #1;
    chk("table_inflight", 64'(inflight), 64'd7);

    // Return routing follows issue order.
    rsp_tready = 4'hF;
    tick();
    for (int i = 0; i < 7; i++) begin
      res_tvalid = 1'b1;
      res_x = DW'(16'hC000 + i);
      #1;
      chk($sformatf("drain%0d_rsp_tvalid", i), 64'(rsp_tvalid), 64'(4'b0001 << exp_ids[i]));
      chk($sformatf("drain%0d_res_tready", i), 64'(res_tready), 64'd1);
      chk($sformatf("drain%0d_rsp_x", i), 64'(rsp_x), 64'(16'hC000 + i));
      tick();
    end
    res_tvalid = 1'b0;
    #1;
    chk("drain_inflight", 64'(inflight), 64'd0);

    // Simultaneous push and pop keeps occupancy.
    tick();
    req_tvalid = 4'b0001; cor_tready = 1'b1;
    tick();
    req_tvalid = 4'b0010; res_tvalid = 1'b1;
    #1;
    chk("pp_rsp_tvalid0", 64'(rsp_tvalid), 64'b0001);
    tick();
    req_tvalid = '0;
    #1;
    chk("pp_inflight", 64'(inflight), 64'd1);
    chk("pp_rsp_tvalid1", 64'(rsp_tvalid), 64'b0010);
    tick();
    res_tvalid = 1'b0;
    #1;
    chk("pp_inflight_end", 64'(inflight), 64'd0);

    // Fill to capacity while head's requester stalls, then drain.
    req_tvalid = 4'b1000;
    repeat (17) tick();
    chk("full_inflight", 64'(inflight), 64'd16);
    chk("full_req_tready", 64'(req_tready), 64'd0);
    chk("full_cor_tvalid", 64'(cor_tvalid), 64'd0);
    res_tvalid = 1'b1; rsp_tready = 4'b0111;
    #1;
    chk("stall_res_tready", 64'(res_tready), 64'd0);
    chk("stall_rsp_tvalid", 64'(rsp_tvalid), 64'b1000);
    repeat (10) tick();
    chk("stall_inflight", 64'(inflight), 64'd16);
    req_tvalid = '0; rsp_tready = 4'hF;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("fdrain%0d_rsp_tvalid", i), 64'(rsp_tvalid), 64'b1000);
      tick();
    end
    res_tvalid = 1'b0;
    #1;
    chk("fdrain_inflight", 64'(inflight), 64'd0);

    // Result with nothing in flight.
    tick();
    res_tvalid = 1'b1;
    #1;
    chk("orphan_res_tready", 64'(res_tready), 64'd1);
    chk("orphan_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
    chk("orphan_err_before", 64'(err), 64'd0);
    tick();
    res_tvalid = 1'b0;
    tick(); tick();
    chk("orphan_err_sticky", 64'(err), 64'd1);
    chk("orphan_inflight", 64'(inflight), 64'd0);

    // Reset with operations in flight.
    req_tvalid = 4'b0001; cor_tready = 1'b1;
    repeat (6) tick();
    req_tvalid = '0;
    chk("pre_rst_inflight", 64'(inflight), 64'd6);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    req_tvalid = 4'b1111; cor_tready = 1'b0;
    #1;
    chk("mid_rst_inflight", 64'(inflight), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_cor_x", 64'(cor_x), 64'h0100);
    chk("mid_rst_req_tready", 64'(req_tready), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
